// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit decoder for the sequential multiplier.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

  typedef struct packed {
    logic single;
    logic dbl;
    logic neg;
  } booth_sel_t;

  // Map a 3-bit overlapping multiplier window onto the {0, +-a, +-2a} selection.
  function automatic booth_sel_t booth_decode(input logic [2:0] digit);
    booth_sel_t sel;
    sel = '0;
    case (digit)
      3'b001, 3'b010: sel.single = 1'b1;
      3'b011:         sel.dbl    = 1'b1;
      3'b100: begin
        sel.dbl = 1'b1;
        sel.neg = 1'b1;
      end
      3'b101, 3'b110: begin
        sel.single = 1'b1;
        sel.neg    = 1'b1;
      end
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Radix-4 Booth partial-product generator: magnitude select only, negation left to the adder.
module booth_r4_pp
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       digit,
  input  logic [WIDTH+1:0] a_ext,
  output logic [WIDTH+2:0] pp_c,
  output logic             neg_c
);

  booth_sel_t sel;

  always_comb begin
    sel   = booth_decode(digit);
    pp_c  = '0;
    neg_c = sel.neg;
    if (sel.single) begin
      pp_c = {a_ext[WIDTH+1], a_ext};
    end else if (sel.dbl) begin
      pp_c = {a_ext, 1'b0};
    end
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier retiring one digit per cycle, valid/ready on both sides.
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned NDIG = (WIDTH + 2) / 2;
  localparam int unsigned EW   = WIDTH + 2;
  localparam int unsigned PW   = WIDTH + 3;
  localparam int unsigned BW   = WIDTH + 3;
  localparam int unsigned AW   = 2 * WIDTH + 4;
  localparam int unsigned RW   = 2 * WIDTH;
  localparam int unsigned CW   = $clog2(NDIG);

  mult_state_t   state, state_next;
  logic [EW-1:0] a_ext, a_ext_next;
  logic [BW-1:0] bx, bx_next;
  logic [AW-1:0] acc, acc_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          in_ready_next, out_valid_next;
  logic [RW-1:0] product_next;

  logic [CW-1:0] step;
  logic [CW:0]   shamt;
  logic [2:0]    digit;
  logic [PW-1:0] pp_c, pp_sel;
  logic          neg_c;
  logic [AW-1:0] addend, carry, sum;
  logic [EW-1:0] a_in_ext, b_in_ext;

  assign a_in_ext = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign b_in_ext = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  // Digit index and weight grow as cnt counts down; bx carries the implicit b_ext[-1]=0 at bit 0.
  assign step  = CW'(NDIG - 1) - cnt;
  assign shamt = {step, 1'b0};
  assign digit = 3'(bx >> shamt);

  booth_r4_pp #(.WIDTH(WIDTH)) u_pp (
    .digit (digit),
    .a_ext (a_ext),
    .pp_c  (pp_c),
    .neg_c (neg_c)
  );

  // Negation is one's complement here plus a +1 injected at the digit's weight.
  assign pp_sel = pp_c ^ {PW{neg_c}};
  assign addend = {{(AW - PW){pp_sel[PW-1]}}, pp_sel} << shamt;
  assign carry  = AW'(neg_c) << shamt;
  assign sum    = acc + addend + carry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_ext     <= '0;
      bx        <= '0;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
    end else begin
      state     <= state_next;
      a_ext     <= a_ext_next;
      bx        <= bx_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
      product   <= product_next;
    end
  end

  always_comb begin
    state_next     = state;
    a_ext_next     = a_ext;
    bx_next        = bx;
    acc_next       = acc;
    cnt_next       = cnt;
    in_ready_next  = in_ready;
    out_valid_next = out_valid;
    product_next   = product;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_next    = BUSY;
          a_ext_next    = a_in_ext;
          bx_next       = {b_in_ext, 1'b0};
          acc_next      = '0;
          cnt_next      = CW'(NDIG - 1);
          in_ready_next = 1'b0;
        end
      end
      BUSY: begin
        acc_next = sum;
        if (cnt == '0) begin
          state_next     = DONE;
          out_valid_next = 1'b1;
          product_next   = sum[RW-1:0];
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
          in_ready_next  = 1'b1;
        end
      end
      default: begin
        state_next     = IDLE;
        in_ready_next  = 1'b1;
        out_valid_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Randomised bench for booth_r4_seq_mult at WIDTH=32 and WIDTH=8 against plain integer multiplication.
module tb_booth_r4_seq_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv32 = 1'b0, rdy32, s32 = 1'b0, ov32, or32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] prod32;

  logic        iv8 = 1'b0, rdy8, s8 = 1'b0, ov8, or8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] prod8;

  int n_cmp = 0;
  int n_err = 0;

  booth_r4_seq_mult #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .is_signed(s32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .product(prod32)
  );

  booth_r4_seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .is_signed(s8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .product(prod8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'({32'b0, a});
    y = s ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(x * y);
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int x, y;
    x = s ? int'($signed(a)) : int'({24'b0, a});
    y = s ? int'($signed(b)) : int'({24'b0, b});
    return 16'(x * y);
  endfunction

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold,
                      output logic [63:0] p, output int lat);
    int n;
    logic [63:0] held;
    n = 0;
    while (!rdy32 && n < 64) begin @(posedge clk); #1; n++; end
    if (!rdy32) check("in_ready32_timeout", 64'(rdy32), 64'd1);
    a32 = a; b32 = b; s32 = s; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 64) begin @(posedge clk); #1; lat++; end
    if (!ov32) check("out_valid32_timeout", 64'(ov32), 64'd1);
    held = prod32;
    for (int k = 0; k < hold; k++) begin
      iv32 = 1'b1; a32 = $urandom; b32 = $urandom; s32 = 1'($urandom);
      @(posedge clk); #1;
      check("hold_valid32", 64'(ov32), 64'd1);
      check("hold_product32", prod32, held);
      check("ready_in_done32", 64'(rdy32), 64'd0);
    end
    iv32 = 1'b0;
    p = prod32;
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    check("release32", 64'(ov32), 64'd0);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input int hold,
                     output logic [15:0] p, output int lat);
    int n;
    logic [15:0] held;
    n = 0;
    while (!rdy8 && n < 64) begin @(posedge clk); #1; n++; end
    if (!rdy8) check("in_ready8_timeout", 64'(rdy8), 64'd1);
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 64) begin @(posedge clk); #1; lat++; end
    if (!ov8) check("out_valid8_timeout", 64'(ov8), 64'd1);
    held = prod8;
    for (int k = 0; k < hold; k++) begin
      iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      check("hold_product8", 64'(prod8), 64'(held));
      check("ready_in_done8", 64'(rdy8), 64'd0);
    end
    iv8 = 1'b0;
    p = prod8;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    check("release8", 64'(ov8), 64'd0);
  endtask

  initial begin
    logic [63:0] p64;
    logic [15:0] p16;
    logic [31:0] ra, rb;
    logic [7:0]  qa, qb;
    logic        rs;
    int          lat;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready32", 64'(rdy32), 64'd1);
    check("rst_out_valid32", 64'(ov32), 64'd0);
    check("rst_product32", prod32, 64'd0);
    check("rst_product8", 64'(prod8), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op32(32'd3, 32'hFFFF_FFF9, 1'b1, 0, p64, lat);
    check("s_3_x_m7", p64, 64'hFFFF_FFFF_FFFF_FFEB);
    check("latency32", 64'(lat), 64'd17);
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, 0, p64, lat);
    check("s_minneg_sq", p64, 64'h4000_0000_0000_0000);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, p64, lat);
    check("s_m1_sq", p64, 64'h1);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, p64, lat);
    check("u_max_sq", p64, 64'hFFFF_FFFE_0000_0001);
    op32(32'd25, 32'd39, 1'b0, 5, p64, lat);
    check("u_25_x_39", p64, 64'd975);
    op32(32'd0, 32'h1234_5678, 1'b1, 0, p64, lat);
    check("zero_op", p64, 64'd0);
    check("zero_latency", 64'(lat), 64'd17);
    op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0, p64, lat);
    check("pre_reset_op", p64, ref32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0));

    // Abort in the eighth busy cycle; product still holds the previous nonzero result.
    a32 = 32'd7; b32 = 32'd9; s32 = 1'b0; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_in_ready", 64'(rdy32), 64'd1);
    check("abort_out_valid", 64'(ov32), 64'd0);
    check("abort_product", prod32, 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_valid", 64'(ov32), 64'd0);
    op32(32'd3, 32'd5, 1'b0, 0, p64, lat);
    check("after_abort", p64, 64'd15);

    for (int i = 0; i < 2000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      if (i % 7 == 0) ra = {ra[31], 31'b0};
      if (i % 11 == 0) rb = ~32'd0;
      op32(ra, rb, rs, int'($urandom_range(0, 2)), p64, lat);
      check("rand32", p64, ref32(ra, rb, rs));
    end

    op8(8'h80, 8'h80, 1'b1, 0, p16, lat);
    check("s8_minneg_sq", 64'(p16), 64'h4000);
    check("latency8", 64'(lat), 64'd5);
    op8(8'hFF, 8'hFF, 1'b0, 2, p16, lat);
    check("u8_max_sq", 64'(p16), 64'hFE01);
    for (int i = 0; i < 2500; i++) begin
      qa = 8'($urandom); qb = 8'($urandom); rs = 1'($urandom);
      op8(qa, qb, rs, int'($urandom_range(0, 1)), p16, lat);
      check("rand8", 64'(p16), 64'(ref8(qa, qb, rs)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
